// File: rtl/fault_sense_cond.sv
// fault_sense_cond
// Sensor conditioning ahead of the fault-detection FSM. Raw pack voltage,
// current and temperature samples are compared against programmable
// thresholds with hysteresis. Each resulting flag is debounced over
// consecutive samples. An idle counter flags a stale sample stream.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   sample_valid  current cycle carries a sample (no backpressure)
//   v_meas        pack voltage sample            [W_V]
//   i_meas        current magnitude sample       [W_I]
//   t_meas        temperature sample             [W_T]
//   thr_ov/uv     over/under-voltage thresholds  [W_V]
//   thr_uc        over-current threshold         [W_I]
//   thr_ot        over-temperature threshold     [W_T]
//   ov/uv/ot/uc   debounced fault flags (registered)
//   flag_chg      one-cycle pulse alongside any flag toggle
//   stale         sample stream timed out (registered)
module fault_sense_cond #(
  parameter int W_V     = 12,
  parameter int W_I     = 12,
  parameter int W_T     = 10,
  parameter int HYST_V  = 16,
  parameter int HYST_I  = 8,
  parameter int HYST_T  = 4,
  parameter int DEB     = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_valid,
  input  logic [W_V-1:0] v_meas,
  input  logic [W_I-1:0] i_meas,
  input  logic [W_T-1:0] t_meas,
  input  logic [W_V-1:0] thr_ov,
  input  logic [W_V-1:0] thr_uv,
  input  logic [W_I-1:0] thr_uc,
  input  logic [W_T-1:0] thr_ot,
  output logic           ov,
  output logic           uv,
  output logic           ot,
  output logic           uc,
  output logic           flag_chg,
  output logic           stale
);

  localparam int WV1 = W_V + 1;
  localparam int WI1 = W_I + 1;
  localparam int WT1 = W_T + 1;

  // Hysteresis bands widened by one bit so the saturation tests cannot wrap.
  localparam logic [W_V:0] HYST_V_X  = WV1'(HYST_V);
  localparam logic [W_I:0] HYST_I_X  = WI1'(HYST_I);
  localparam logic [W_T:0] HYST_T_X  = WT1'(HYST_T);
  localparam logic [W_V:0] V_MAX_X   = {1'b0, {W_V{1'b1}}};
  localparam logic [3:0]   DEB_C     = 4'(DEB);
  localparam logic [15:0]  TIMEOUT_C = 16'(TIMEOUT);

  // One debounce step: returns {toggled, next_flag, next_count}.
  function automatic logic [5:0] deb_step(input logic tgt, input logic flag,
                                          input logic [3:0] cnt);
    logic [3:0] inc;
    inc = cnt + 4'd1;
    if (tgt == flag) begin
      deb_step = {1'b0, flag, 4'd0};
    end else if (inc == DEB_C) begin
      deb_step = {1'b1, ~flag, 4'd0};
    end else begin
      deb_step = {1'b0, flag, inc};
    end
  endfunction

  // Stage-1 registers: sample and thresholds captured together
  logic           s1_valid_r;
  logic [W_V-1:0] v_r;
  logic [W_I-1:0] i_r;
  logic [W_T-1:0] t_r;
  logic [W_V-1:0] thr_ov_r;
  logic [W_V-1:0] thr_uv_r;
  logic [W_I-1:0] thr_uc_r;
  logic [W_T-1:0] thr_ot_r;

  // Flag, debounce and idle state
  logic        ov_r, uv_r, ot_r, uc_r, flag_chg_r, stale_r;
  logic [3:0]  ov_cnt_r, uv_cnt_r, ot_cnt_r, uc_cnt_r;
  logic [15:0] idle_cnt_r;

  // Combinational hysteresis bounds and targets
  logic [W_V-1:0] ov_lo_s;
  logic [W_V:0]   uv_sum_s;
  logic [W_V-1:0] uv_hi_s;
  logic [W_I-1:0] uc_lo_s;
  logic [W_T-1:0] ot_lo_s;
  logic           ov_tgt_s, uv_tgt_s, uc_tgt_s, ot_tgt_s;
  logic [5:0]     ov_step_s, uv_step_s, uc_step_s, ot_step_s;
  logic           upd_s;

  // Capture an accepted sample with its thresholds; reset drops any in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      v_r        <= '0;
      i_r        <= '0;
      t_r        <= '0;
      thr_ov_r   <= '0;
      thr_uv_r   <= '0;
      thr_uc_r   <= '0;
      thr_ot_r   <= '0;
    end else begin
      s1_valid_r <= sample_valid;
      if (sample_valid) begin
        v_r      <= v_meas;
        i_r      <= i_meas;
        t_r      <= t_meas;
        thr_ov_r <= thr_ov;
        thr_uv_r <= thr_uv;
        thr_uc_r <= thr_uc;
        thr_ot_r <= thr_ot;
      end
    end
  end

  // Saturating hysteresis bounds (clear points) for each channel
  always_comb begin
    ov_lo_s  = '0;
    uv_sum_s = '0;
    uv_hi_s  = '0;
    uc_lo_s  = '0;
    ot_lo_s  = '0;
    if ({1'b0, thr_ov_r} > HYST_V_X) begin
      ov_lo_s = thr_ov_r - HYST_V_X[W_V-1:0];
    end else begin
      ov_lo_s = '0;
    end
    uv_sum_s = {1'b0, thr_uv_r} + HYST_V_X;
    if (uv_sum_s > V_MAX_X) begin
      uv_hi_s = '1;
    end else begin
      uv_hi_s = uv_sum_s[W_V-1:0];
    end
    if ({1'b0, thr_uc_r} > HYST_I_X) begin
      uc_lo_s = thr_uc_r - HYST_I_X[W_I-1:0];
    end else begin
      uc_lo_s = '0;
    end
    if ({1'b0, thr_ot_r} > HYST_T_X) begin
      ot_lo_s = thr_ot_r - HYST_T_X[W_T-1:0];
    end else begin
      ot_lo_s = '0;
    end
  end

  // Hysteresis targets: set strictly beyond threshold, clear beyond band, else hold
  always_comb begin
    ov_tgt_s = ov_r;
    uv_tgt_s = uv_r;
    uc_tgt_s = uc_r;
    ot_tgt_s = ot_r;
    if (v_r > thr_ov_r) begin
      ov_tgt_s = 1'b1;
    end else if (v_r < ov_lo_s) begin
      ov_tgt_s = 1'b0;
    end else begin
      ov_tgt_s = ov_r;
    end
    if (v_r < thr_uv_r) begin
      uv_tgt_s = 1'b1;
    end else if (v_r > uv_hi_s) begin
      uv_tgt_s = 1'b0;
    end else begin
      uv_tgt_s = uv_r;
    end
    if (i_r > thr_uc_r) begin
      uc_tgt_s = 1'b1;
    end else if (i_r < uc_lo_s) begin
      uc_tgt_s = 1'b0;
    end else begin
      uc_tgt_s = uc_r;
    end
    if (t_r > thr_ot_r) begin
      ot_tgt_s = 1'b1;
    end else if (t_r < ot_lo_s) begin
      ot_tgt_s = 1'b0;
    end else begin
      ot_tgt_s = ot_r;
    end
  end

  // Debounce steps; state only advances on a registered sample while not stale
  always_comb begin
    upd_s     = s1_valid_r & ~stale_r;
    ov_step_s = deb_step(ov_tgt_s, ov_r, ov_cnt_r);
    uv_step_s = deb_step(uv_tgt_s, uv_r, uv_cnt_r);
    uc_step_s = deb_step(uc_tgt_s, uc_r, uc_cnt_r);
    ot_step_s = deb_step(ot_tgt_s, ot_r, ot_cnt_r);
  end

  // Flag and debounce counter registers with the change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_r       <= 1'b0;
      uv_r       <= 1'b0;
      ot_r       <= 1'b0;
      uc_r       <= 1'b0;
      ov_cnt_r   <= 4'd0;
      uv_cnt_r   <= 4'd0;
      ot_cnt_r   <= 4'd0;
      uc_cnt_r   <= 4'd0;
      flag_chg_r <= 1'b0;
    end else if (upd_s) begin
      ov_r       <= ov_step_s[4];
      ov_cnt_r   <= ov_step_s[3:0];
      uv_r       <= uv_step_s[4];
      uv_cnt_r   <= uv_step_s[3:0];
      uc_r       <= uc_step_s[4];
      uc_cnt_r   <= uc_step_s[3:0];
      ot_r       <= ot_step_s[4];
      ot_cnt_r   <= ot_step_s[3:0];
      flag_chg_r <= ov_step_s[5] | uv_step_s[5] | uc_step_s[5] | ot_step_s[5];
    end else begin
      flag_chg_r <= 1'b0;
    end
  end

  // Saturating idle counter and stale flag; any sample clears both
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r <= 16'd0;
      stale_r    <= 1'b0;
    end else if (sample_valid) begin
      idle_cnt_r <= 16'd0;
      stale_r    <= 1'b0;
    end else begin
      if (idle_cnt_r != 16'hFFFF) begin
        idle_cnt_r <= idle_cnt_r + 16'd1;
      end
      // Counter already at TIMEOUT before this edge: stale lands TIMEOUT+1 after the last sample
      if (idle_cnt_r >= TIMEOUT_C) begin
        stale_r <= 1'b1;
      end
    end
  end

  assign ov       = ov_r;
  assign uv       = uv_r;
  assign ot       = ot_r;
  assign uc       = uc_r;
  assign flag_chg = flag_chg_r;
  assign stale    = stale_r;

endmodule

// File: tb/tb_fault_sense_cond.sv
// Directed bench for fault_sense_cond: default instance (DEB=3) plus a
// DEB=1 instance sharing the same stimulus for the simultaneous-flag case.
module tb_fault_sense_cond;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [11:0] v_meas, i_meas, thr_ov, thr_uv, thr_uc;
  logic [9:0]  t_meas, thr_ot;

  logic ov, uv, ot, uc, flag_chg, stale;
  logic ov1, uv1, ot1, uc1, flag_chg1, stale1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fault_sense_cond dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .v_meas(v_meas), .i_meas(i_meas), .t_meas(t_meas),
    .thr_ov(thr_ov), .thr_uv(thr_uv), .thr_uc(thr_uc), .thr_ot(thr_ot),
    .ov(ov), .uv(uv), .ot(ot), .uc(uc), .flag_chg(flag_chg), .stale(stale)
  );

  fault_sense_cond #(.DEB(1)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .v_meas(v_meas), .i_meas(i_meas), .t_meas(t_meas),
    .thr_ov(thr_ov), .thr_uv(thr_uv), .thr_uc(thr_uc), .thr_ot(thr_ot),
    .ov(ov1), .uv(uv1), .ot(ot1), .uc(uc1), .flag_chg(flag_chg1), .stale(stale1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ov,uv,ot,uc,flag_chg}
  task automatic chk0(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, ov, uv, ot, uc, flag_chg}, {27'd0, exp});
  endtask

  task automatic chk1(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, ov1, uv1, ot1, uc1, flag_chg1}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [11:0] v, input logic [11:0] i, input logic [9:0] t);
    sample_valid = 1'b1;
    v_meas = v;
    i_meas = i;
    t_meas = t;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates a concurrent full-scale sample
    rst = 1'b1; sample_valid = 1'b1;
    v_meas = 12'd4095; i_meas = 12'd4095; t_meas = 10'd1023;
    thr_ov = 12'd3000; thr_uv = 12'd100; thr_uc = 12'd4000; thr_ot = 10'd1000;
    idle(3);
    chk0("rst_hold", 5'b00000);
    chk1("rst_hold_deb1", 5'b00000);
    check("rst_stale", {31'd0, stale}, 32'd0);
    rst = 1'b0; sample_valid = 1'b0;
    idle(3);
    chk0("post_rst", 5'b00000);
    chk1("post_rst_deb1", 5'b00000);

    // ov rise after three samples, hysteresis hold, fall, exact threshold
    send(12'd3001, 12'd0, 10'd300);
    send(12'd3001, 12'd0, 10'd300);
    send(12'd3001, 12'd0, 10'd300);
    chk0("ov_pend", 5'b00000);
    tick();
    chk0("ov_rise", 5'b10001);
    tick();
    chk0("ov_chg_once", 5'b10000);
    send(12'd2990, 12'd0, 10'd300);
    idle(2);
    chk0("ov_band", 5'b10000);
    send(12'd2983, 12'd0, 10'd300);
    send(12'd2983, 12'd0, 10'd300);
    send(12'd2983, 12'd0, 10'd300);
    tick();
    chk0("ov_fall", 5'b00001);
    tick();
    chk0("ov_fall_done", 5'b00000);
    send(12'd3000, 12'd0, 10'd300);
    send(12'd3000, 12'd0, 10'd300);
    send(12'd3000, 12'd0, 10'd300);
    idle(2);
    chk0("ov_eq_thr", 5'b00000);

    // ot debounce counter cleared by an agreeing sample
    thr_ot = 10'd500;
    send(12'd2000, 12'd0, 10'd501);
    send(12'd2000, 12'd0, 10'd501);
    send(12'd2000, 12'd0, 10'd400);
    send(12'd2000, 12'd0, 10'd501);
    send(12'd2000, 12'd0, 10'd501);
    idle(2);
    chk0("ot_deb_reset", 5'b00000);
    send(12'd2000, 12'd0, 10'd501);
    idle(2);
    chk0("ot_rise", 5'b00100);
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    idle(2);
    chk0("ot_fall", 5'b00000);

    // uv set, then clear bound saturates at full scale
    thr_uv = 12'd4090; thr_ov = 12'd4095;
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    idle(2);
    chk0("uv_set", 5'b01000);
    send(12'd4095, 12'd0, 10'd300);
    send(12'd4095, 12'd0, 10'd300);
    send(12'd4095, 12'd0, 10'd300);
    idle(2);
    chk0("uv_sat_hold", 5'b01000);

    // Stale: last sample two edges ago, stale expected 1001 edges after it
    idle(998);
    check("stale_early", {31'd0, stale}, 32'd0);
    tick();
    check("stale_set", {31'd0, stale}, 32'd1);
    idle(5);
    check("stale_hold", {31'd0, stale}, 32'd1);
    chk0("stale_flags_held", 5'b01000);

    // Recovery: stale clears at once, uv needs DEB samples
    thr_uv = 12'd100; thr_ov = 12'd3000;
    send(12'd2000, 12'd0, 10'd300);
    check("stale_clr", {31'd0, stale}, 32'd0);
    idle(2);
    chk0("uv_one_sample", 5'b01000);
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    tick();
    chk0("uv_clear", 5'b00001);

    // uc set, then clear bound saturates at zero
    thr_uc = 12'd5;
    send(12'd2000, 12'd6, 10'd300);
    send(12'd2000, 12'd6, 10'd300);
    send(12'd2000, 12'd6, 10'd300);
    idle(2);
    chk0("uc_set", 5'b00010);
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    send(12'd2000, 12'd0, 10'd300);
    idle(2);
    chk0("uc_sat_hold", 5'b00010);

    // Mid-run reset, then simultaneous flags on the DEB=1 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk0("mid_rst", 5'b00000);
    chk1("mid_rst_deb1", 5'b00000);
    thr_uc = 12'd3000; thr_ot = 10'd800;
    send(12'd3500, 12'd4000, 10'd900);
    chk1("sim_pend", 5'b00000);
    tick();
    chk1("sim_rise", 5'b10111);
    chk0("sim_deb3", 5'b00000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("sim_rst", 5'b00000);

    // A registered sample still in flight when reset hits is dropped
    send(12'd3500, 12'd4000, 10'd900);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    chk1("inflight_discard", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
